alu_sequencer: RTL and testbench

Microcoded sequencer that runs a short stored program on the 4-bit arithmetic unit. It holds a 16-word program RAM and four 4-bit registers, drives the ALU operand and opcode inputs, and writes R and Status back. It sits between the prescaler enable and the ALU, in the slot the hand-driven control unit occupies. It advances one FSM step per prescaler enable pulse.

---
 rtl/alu_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: microcoded sequencer for the 4-bit ALU.
// It holds a 16-word program RAM and four 4-bit working registers.
// It drives the ALU operand and opcode ports and commits iR/iStatus on write-back.
// The FSM advances only on clock edges where the prescaler enable (en) is high.
// Optional feature macro: SEQ_WATCHDOG_EN. When defined, an 8-bit step counter
// aborts runaway programs after MAX_STEPS write-backs.
module alu_sequencer #(
  parameter int PROG_DEPTH = 16,
  parameter int MAX_STEPS  = 255,
  localparam int PCW       = $clog2(PROG_DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           start,
  input  logic           prog_we,
  input  logic [PCW-1:0] prog_addr,
  input  logic [13:0]    prog_data,
  output logic [3:0]     oA,
  output logic [3:0]     oB,
  output logic [3:0]     oOp,
  input  logic [3:0]     iR,
  input  logic [4:0]     iStatus,
  output logic [PCW-1:0] pc,
  output logic [3:0]     oR0,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic           led
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic [1:0]     CLS_ALU   = 2'b00;
  localparam logic [1:0]     CLS_LOADI = 2'b01;
  localparam logic [1:0]     CLS_BRZ   = 2'b10;
  localparam logic [1:0]     CLS_HALT  = 2'b11;
  localparam logic [PCW-1:0] PC_ZERO   = {PCW{1'b0}};
  localparam logic [PCW-1:0] PC_ONE    = {{(PCW-1){1'b0}}, 1'b1};

  // Program storage. It is deliberately not reset so a program survives rst.
  logic [13:0] mem_r [PROG_DEPTH];

  // Architectural state, current (_r) and next (_s).
  state_t          state_r,  state_s;
  logic [PCW-1:0]  pc_r,     pc_s;
  logic [3:0][3:0] regs_r,   regs_s;
  logic [4:0]      status_r, status_s;
  logic [13:0]     ir_r,     ir_s;
  logic [3:0]      oa_r,     oa_s;
  logic [3:0]      ob_r,     ob_s;
  logic [3:0]      op_r,     op_s;
  logic            busy_r,   busy_s;
  logic            done_r,   done_s;

`ifdef SEQ_WATCHDOG_EN
  localparam logic [7:0] STEP_LIMIT = 8'(MAX_STEPS);
  logic [7:0] step_r, step_s;
  logic       err_r,  err_s;
`endif

  // Decoded fields of the word being fetched and of the latched instruction.
  logic [13:0] fetch_s;
  logic [1:0]  fetch_cls_s;
  logic [1:0]  fetch_rd_s;
  logic [1:0]  fetch_rs_s;
  logic [3:0]  fetch_op_s;
  logic [1:0]  ir_cls_s;
  logic [1:0]  ir_rd_s;
  logic [3:0]  ir_imm_s;
  logic        prog_ok_s;

  assign fetch_s     = mem_r[pc_r];
  assign fetch_cls_s = fetch_s[13:12];
  assign fetch_op_s  = fetch_s[11:8];
  assign fetch_rd_s  = fetch_s[7:6];
  assign fetch_rs_s  = fetch_s[5:4];
  assign ir_cls_s    = ir_r[13:12];
  assign ir_rd_s     = ir_r[7:6];
  assign ir_imm_s    = ir_r[3:0];

  // Operands are taken from the fetched word. The latched opcode and rs bits,
  // and the upper status flags, are kept for visibility only.
  logic ir_unused_s;
  logic status_unused_s;
  assign ir_unused_s     = ^{ir_r[11:8], ir_r[5:4]};
  assign status_unused_s = ^status_r[4:1];

  // The RAM can only be rewritten while no program is running.
  assign prog_ok_s = (state_r == ST_IDLE) || (state_r == ST_HALT);

  // Program RAM write port. It is independent of the step enable.
  always_ff @(posedge clk) begin
    if (prog_we && prog_ok_s) begin
      mem_r[prog_addr] <= prog_data;
    end
  end

  // Next-state and next-output logic for the sequencer FSM.
  always_comb begin
    state_s  = state_r;
    pc_s     = pc_r;
    regs_s   = regs_r;
    status_s = status_r;
    ir_s     = ir_r;
    oa_s     = oa_r;
    ob_s     = ob_r;
    op_s     = op_r;
    busy_s   = busy_r;
    done_s   = done_r;
`ifdef SEQ_WATCHDOG_EN
    step_s   = step_r;
    err_s    = err_r;
`endif
    case (state_r)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_s  = ST_FETCH;
          pc_s     = PC_ZERO;
          regs_s   = 16'd0;
          status_s = 5'd0;
          busy_s   = 1'b1;
          done_s   = 1'b0;
`ifdef SEQ_WATCHDOG_EN
          step_s   = 8'd0;
          err_s    = 1'b0;
`endif
        end else begin
          state_s = state_r;
        end
      end
      ST_FETCH: begin
        ir_s    = fetch_s;
        state_s = ST_EXEC;
        // Operands are registered here so they are stable during EXEC and WB.
        if (fetch_cls_s == CLS_ALU) begin
          oa_s = regs_r[fetch_rd_s];
          ob_s = regs_r[fetch_rs_s];
          op_s = fetch_op_s;
        end else begin
          oa_s = 4'd0;
          ob_s = 4'd0;
          op_s = 4'd0;
        end
      end
      ST_EXEC: begin
        if (ir_cls_s == CLS_HALT) begin
          state_s = ST_HALT;
          done_s  = 1'b1;
          busy_s  = 1'b0;
        end else begin
          state_s = ST_WB;
        end
      end
      ST_WB: begin
        state_s = ST_FETCH;
        oa_s    = 4'd0;
        ob_s    = 4'd0;
        op_s    = 4'd0;
        pc_s    = pc_r + PC_ONE;
        case (ir_cls_s)
          CLS_ALU: begin
            regs_s[ir_rd_s] = iR;
            status_s        = iStatus;
          end
          CLS_LOADI: begin
            regs_s[ir_rd_s] = ir_imm_s;
          end
          CLS_BRZ: begin
            if (status_r[0]) begin
              pc_s = PCW'(ir_imm_s);
            end else begin
              pc_s = pc_r + PC_ONE;
            end
          end
          default: begin
            regs_s = regs_r;
          end
        endcase
`ifdef SEQ_WATCHDOG_EN
        step_s = step_r + 8'd1;
        if (step_s == STEP_LIMIT) begin
          state_s = ST_HALT;
          busy_s  = 1'b0;
          done_s  = 1'b0;
          err_s   = 1'b1;
        end else begin
          err_s = err_r;
        end
`endif
      end
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
        done_s  = 1'b0;
      end
    endcase
  end

  // State register. Async reset clears everything; otherwise it steps only on en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_IDLE;
      pc_r     <= PC_ZERO;
      regs_r   <= 16'd0;
      status_r <= 5'd0;
      ir_r     <= 14'd0;
      oa_r     <= 4'd0;
      ob_r     <= 4'd0;
      op_r     <= 4'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      step_r   <= 8'd0;
      err_r    <= 1'b0;
`endif
    end else if (en) begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      regs_r   <= regs_s;
      status_r <= status_s;
      ir_r     <= ir_s;
      oa_r     <= oa_s;
      ob_r     <= ob_s;
      op_r     <= op_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
`ifdef SEQ_WATCHDOG_EN
      step_r   <= step_s;
      err_r    <= err_s;
`endif
    end
  end

  assign oA   = oa_r;
  assign oB   = ob_r;
  assign oOp  = op_r;
  assign pc   = pc_r;
  assign oR0  = regs_r[0];
  assign busy = busy_r;
  assign done = done_r;
  assign led  = done_r;

`ifdef SEQ_WATCHDOG_EN
  assign err = err_r;
`else
  // Without the watchdog there is no abort path; MAX_STEPS has no effect.
  logic [7:0] step_limit_unused_s;
  assign step_limit_unused_s = 8'(MAX_STEPS);
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: table-driven program runs checked through a
// scoreboard queue, plus hand-written timing, guard, reset and watchdog sequences.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst, en, start, prog_we;
  logic [3:0]  prog_addr;
  logic [13:0] prog_data;
  logic [3:0]  oA, oB, oOp, iR, pc, oR0;
  logic [4:0]  iStatus;
  logic        busy, done, err, led;

  int passed = 0;
  int total  = 0;

  localparam logic [13:0] HALT_W = 14'h3000;

  typedef struct packed {
    logic [15:0][13:0] prog;
    logic [3:0]        r0;
    logic [3:0]        pc;
    logic [7:0]        edges;
    logic [1:0]        gap;
  } vec_t;

  typedef struct packed {
    logic [3:0] r0;
    logic [3:0] pc;
    logic [7:0] edges;
  } exp_t;

  vec_t vecs [7];
  exp_t exp_q [$];

  alu_sequencer #(.PROG_DEPTH(16), .MAX_STEPS(5)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .oA(oA), .oB(oB), .oOp(oOp), .iR(iR), .iStatus(iStatus),
    .pc(pc), .oR0(oR0), .busy(busy), .done(done), .err(err), .led(led)
  );

  always #5 clk = ~clk;

  // Reference ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, others pass A.
  // Status bit 0 is zero and bit 1 is carry/borrow.
  function automatic logic [8:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [3:0] op);
    logic [4:0] w;
    case (op)
      4'd0:    w = {1'b0, a} + {1'b0, b};
      4'd1:    w = {1'b0, a} - {1'b0, b};
      4'd2:    w = {1'b0, a & b};
      4'd3:    w = {1'b0, a | b};
      4'd4:    w = {1'b0, a ^ b};
      default: w = {1'b0, a};
    endcase
    return {3'b000, w[4], (w[3:0] == 4'd0), w[3:0]};
  endfunction

  assign {iStatus, iR} = alu_model(oA, oB, oOp);

  function automatic logic [13:0] ldi(input logic [1:0] rd, input logic [3:0] imm);
    return {2'b01, 4'd0, rd, 2'd0, imm};
  endfunction

  function automatic logic [13:0] alu(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs);
    return {2'b00, op, rd, rs, 4'd0};
  endfunction

  function automatic logic [13:0] brz(input logic [3:0] t);
    return {2'b10, 4'd0, 4'd0, t};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // One enabled edge, preceded by `gap` disabled edges during which nothing may move.
  task automatic edge_en(input int gap);
    logic [21:0] snap;
    for (int i = 0; i < gap; i++) begin
      snap = {pc, busy, done, oA, oB, oOp, oR0};
      en = 1'b0;
      @(posedge clk); #1;
      check("en_hold", {10'd0, pc, busy, done, oA, oB, oOp, oR0}, {10'd0, snap});
    end
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic write_word(input logic [3:0] a, input logic [13:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  task automatic load(input logic [15:0][13:0] p);
    for (int i = 0; i < 16; i++) write_word(4'(i), p[i]);
  endtask

  // Start a run and step until busy drops or the edge budget runs out.
  task automatic run(input int gap, input int budget, output int edges, output bit to);
    start = 1'b1;
    edge_en(gap);
    start = 1'b0;
    edges = 0;
    while (busy === 1'b1 && edges < budget) begin
      edge_en(gap);
      edges++;
    end
    to = (busy !== 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, required finished");
    $fatal(1);
  end

  initial begin
    int   edges;
    bit   to;
    exp_t e;

    rst = 1'b0; en = 1'b0; start = 1'b0; prog_we = 1'b0;
    prog_addr = 4'd0; prog_data = 14'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {8'd0, pc, oA, oB, oOp, oR0, busy, done, err, led}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Vector table
    for (int v = 0; v < 7; v++) vecs[v].prog = {16{HALT_W}};
    // Add: 3 + 4
    vecs[0].prog[0] = ldi(2'd0, 4'd3); vecs[0].prog[1] = ldi(2'd1, 4'd4);
    vecs[0].prog[2] = alu(4'd0, 2'd0, 2'd1);
    vecs[0].r0 = 4'd7; vecs[0].pc = 4'd3; vecs[0].edges = 8'd11; vecs[0].gap = 2'd0;
    // Branch taken: 5 - 5 = 0, BRZ 6
    vecs[1].prog[0] = ldi(2'd0, 4'd5); vecs[1].prog[1] = ldi(2'd1, 4'd5);
    vecs[1].prog[2] = alu(4'd1, 2'd0, 2'd1); vecs[1].prog[3] = brz(4'd6);
    vecs[1].prog[4] = ldi(2'd0, 4'd9);
    vecs[1].r0 = 4'd0; vecs[1].pc = 4'd6; vecs[1].edges = 8'd14; vecs[1].gap = 2'd0;
    // Branch not taken: 5 - 3 = 2, fall through and double R0
    vecs[2].prog[0] = ldi(2'd0, 4'd5); vecs[2].prog[1] = ldi(2'd1, 4'd3);
    vecs[2].prog[2] = alu(4'd1, 2'd0, 2'd1); vecs[2].prog[3] = brz(4'd6);
    vecs[2].prog[4] = alu(4'd0, 2'd0, 2'd0);
    vecs[2].r0 = 4'd4; vecs[2].pc = 4'd5; vecs[2].edges = 8'd17; vecs[2].gap = 2'd0;
    // 15 + 1 wraps to 0 with no saturation
    vecs[3].prog[0] = ldi(2'd0, 4'd15); vecs[3].prog[1] = ldi(2'd1, 4'd1);
    vecs[3].prog[2] = alu(4'd0, 2'd0, 2'd1);
    vecs[3].r0 = 4'd0; vecs[3].pc = 4'd3; vecs[3].edges = 8'd11; vecs[3].gap = 2'd0;
    // PC wrap 15->0, status cleared by start, and status kept across LOADI
    vecs[4].prog[0] = brz(4'd5); vecs[4].prog[1] = ldi(2'd1, 4'd0);
    vecs[4].prog[2] = alu(4'd0, 2'd1, 2'd1); vecs[4].prog[3] = brz(4'd15);
    vecs[4].prog[15] = ldi(2'd0, 4'd8);
    vecs[4].r0 = 4'd8; vecs[4].pc = 4'd5; vecs[4].edges = 8'd20; vecs[4].gap = 2'd0;
    // Nonzero rd/rs fields: (12 & 10) = 8, then 6 | 8 = 14
    vecs[5].prog[0] = ldi(2'd2, 4'd12); vecs[5].prog[1] = ldi(2'd3, 4'd10);
    vecs[5].prog[2] = alu(4'd2, 2'd2, 2'd3); vecs[5].prog[3] = ldi(2'd0, 4'd6);
    vecs[5].prog[4] = alu(4'd3, 2'd0, 2'd2);
    vecs[5].r0 = 4'd14; vecs[5].pc = 4'd5; vecs[5].edges = 8'd17; vecs[5].gap = 2'd0;
    // Add program with en high one cycle in four
    vecs[6] = vecs[0];
    vecs[6].gap = 2'd3;

    for (int v = 0; v < 7; v++) begin
      load(vecs[v].prog);
      exp_q.push_back({vecs[v].r0, vecs[v].pc, vecs[v].edges});
      run(int'(vecs[v].gap), 60, edges, to);
      e = exp_q.pop_front();
      check($sformatf("v%0d_timeout", v), {31'd0, to}, 32'd0);
      check($sformatf("v%0d_r0", v), {28'd0, oR0}, {28'd0, e.r0});
      check($sformatf("v%0d_pc", v), {28'd0, pc}, {28'd0, e.pc});
      check($sformatf("v%0d_edges", v), edges, {24'd0, e.edges});
      check($sformatf("v%0d_flags", v), {28'd0, busy, done, led, err}, 32'h6);
    end

    // Operand timing through EXEC/WB/FETCH of the add
    load(vecs[0].prog);
    start = 1'b1; edge_en(0); start = 1'b0;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_pc", {28'd0, pc}, 32'd0);
    check("start_clears_done", {30'd0, done, led}, 32'd0);
    repeat (7) edge_en(0);
    check("exec_operands", {20'd0, oA, oB, oOp}, 32'h340);
    edge_en(0);
    check("wb_hold_operands", {24'd0, oA, oB}, 32'h34);
    check("wb_alu_result", {28'd0, iR}, 32'd7);
    check("wb_r0_pending", {28'd0, oR0}, 32'd3);
    edge_en(0);
    check("fetch_ops_zero", {20'd0, oA, oB, oOp}, 32'd0);
    check("fetch_r0", {28'd0, oR0}, 32'd7);
    edge_en(0);
    check("halt_exec_not_done", {30'd0, busy, done}, 32'h2);
    edge_en(0);
    check("halt_done", {29'd0, busy, done, led}, 32'h3);
    edge_en(0);
    check("done_sticky", {28'd0, pc}, {31'd0, done} * 32'd3);

    // Busy guards: write and start mid-run are ignored
    start = 1'b1; edge_en(0); start = 1'b0;
    repeat (2) edge_en(0);
    edges = 2;
    prog_we = 1'b1; prog_addr = 4'd2; prog_data = ldi(2'd0, 4'd9); start = 1'b1;
    edge_en(0);
    edges++;
    prog_we = 1'b0; start = 1'b0;
    while (busy === 1'b1 && edges < 60) begin edge_en(0); edges++; end
    check("guard_edges", edges, 32'd11);
    check("guard_r0", {28'd0, oR0}, 32'd7);
    check("guard_pc", {28'd0, pc}, 32'd3);
    write_word(4'd2, ldi(2'd0, 4'd9));
    run(0, 60, edges, to);
    check("rewrite_r0", {28'd0, oR0}, 32'd9);
    check("rewrite_done", {30'd0, done, to}, 32'h2);

    // Reset during the WB of the add
    load(vecs[0].prog);
    start = 1'b1; edge_en(0); start = 1'b0;
    repeat (8) edge_en(0);
    check("pre_reset_in_wb", {28'd0, oA}, 32'd3);
    rst = 1'b0;
    #1;
    check("reset_midrun", {8'd0, pc, oA, oB, oOp, oR0, busy, done, err, led}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    run(0, 60, edges, to);
    check("rerun_r0", {28'd0, oR0}, 32'd7);
    check("rerun_edges", edges, 32'd11);

    // Watchdog: ALU sets zero flag, BRZ 0 loops forever
    for (int i = 0; i < 16; i++) vecs[0].prog[i] = HALT_W;
    vecs[0].prog[0] = alu(4'd1, 2'd0, 2'd0);
    vecs[0].prog[1] = brz(4'd0);
    load(vecs[0].prog);
    run(0, 40, edges, to);
`ifdef SEQ_WATCHDOG_EN
    check("wd_flags", {28'd0, err, busy, done, led}, 32'h8);
    check("wd_edges", edges, 32'd15);
    start = 1'b1; edge_en(0); start = 1'b0;
    check("wd_err_clear", {30'd0, err, busy}, 32'h1);
`else
    check("nowd_still_busy", {29'd0, to, busy, err}, 32'h6);
    check("nowd_not_done", {30'd0, done, led}, 32'd0);
`endif
    rst = 1'b0;
    #1;
    check("final_reset", {29'd0, busy, done, err}, 32'd0);
    rst = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
